// File: rtl/frame_sum_sequencer_if.sv
// Pixel stream, line result and frame handshake bundle for frame_sum_sequencer.
// master: pixel source / frame consumer side. slave: the sequencer itself.
interface frame_sum_sequencer_if #(
    parameter int unsigned LINE_SIZE    = 8,
    parameter int unsigned NUM_OF_LINES = 4,
    parameter int unsigned PIXEL_SIZE   = 8
);
    localparam int unsigned LW = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
    localparam int unsigned FW = $clog2(NUM_OF_LINES) + LW;
    localparam int unsigned IW = $clog2(NUM_OF_LINES);

    logic                  in_valid;
    logic                  in_ready;
    logic [PIXEL_SIZE-1:0] pix_a;
    logic [PIXEL_SIZE-1:0] pix_b;
    logic [LW-1:0]         line_sum;
    logic                  line_sum_valid;
    logic [IW-1:0]         line_idx;
    logic [FW-1:0]         frame_sum;
    logic                  frame_valid;
    logic                  frame_ready;

    modport master (
        output in_valid, pix_a, pix_b, frame_ready,
        input  in_ready, line_sum, line_sum_valid, line_idx, frame_sum, frame_valid
    );

    modport slave (
        input  in_valid, pix_a, pix_b, frame_ready,
        output in_ready, line_sum, line_sum_valid, line_idx, frame_sum, frame_valid
    );
endinterface

// File: rtl/frame_sum_sequencer.sv
// Frame sum sequencer: accepts LINE_SIZE x NUM_OF_LINES pixel pairs, strobes out each
// line's sum of products and offers the frame total over a valid/ready handshake.
module frame_sum_sequencer #(
    parameter int unsigned LINE_SIZE    = 8,
    parameter int unsigned NUM_OF_LINES = 4,
    parameter int unsigned PIXEL_SIZE   = 8
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    frame_sum_sequencer_if.slave  bus_io
);
    localparam int unsigned PW = 2 * PIXEL_SIZE;
    localparam int unsigned CW = $clog2(LINE_SIZE);
    localparam int unsigned IW = $clog2(NUM_OF_LINES);
    localparam int unsigned LW = CW + PW;
    localparam int unsigned FW = IW + LW;

    typedef enum logic [1:0] {StIdle, StRun, StOut} state_e;

    state_e          state_q;
    logic [CW-1:0]   pix_cnt_q;
    logic [IW-1:0]   line_cnt_q;
    logic [LW-1:0]   line_acc_q;
    logic [FW-1:0]   frame_acc_q;
    logic [LW-1:0]   line_sum_q;
    logic [IW-1:0]   line_idx_q;
    logic [FW-1:0]   frame_sum_q;
    logic            in_ready_q;
    logic            line_sum_valid_q;
    logic            frame_valid_q;
    logic            busy_q;

    logic            accept;
    logic            last_pix;
    logic            last_line;
    logic [PW-1:0]   prod;
    logic [LW-1:0]   line_total;
    logic [FW-1:0]   frame_total;

    // Product and running totals; the first pixel/line of each group starts from zero,
    // so no residue can survive an abort.
    always_comb begin
        accept      = bus_io.in_valid && in_ready_q;
        last_pix    = (pix_cnt_q == CW'(LINE_SIZE - 1));
        last_line   = (line_cnt_q == IW'(NUM_OF_LINES - 1));
        prod        = PW'(bus_io.pix_a) * PW'(bus_io.pix_b);
        line_total  = ((pix_cnt_q == '0) ? '0 : line_acc_q) + LW'(prod);
        frame_total = ((line_cnt_q == '0) ? '0 : frame_acc_q) + FW'(line_total);
    end

    // Control FSM, counters, accumulators and registered outputs.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            pix_cnt_q        <= '0;
            line_cnt_q       <= '0;
            line_acc_q       <= '0;
            frame_acc_q      <= '0;
            line_sum_q       <= '0;
            line_idx_q       <= '0;
            frame_sum_q      <= '0;
            in_ready_q       <= 1'b0;
            line_sum_valid_q <= 1'b0;
            frame_valid_q    <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            line_sum_valid_q <= 1'b0;
            if (abort) begin
                // Abort beats any handshake this cycle; results from earlier frames are kept.
                state_q       <= StIdle;
                pix_cnt_q     <= '0;
                line_cnt_q    <= '0;
                in_ready_q    <= 1'b0;
                frame_valid_q <= 1'b0;
                busy_q        <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        pix_cnt_q  <= '0;
                        line_cnt_q <= '0;
                        if (start) begin
                            state_q    <= StRun;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (accept) begin
                            line_acc_q <= line_total;
                            if (last_pix) begin
                                pix_cnt_q        <= '0;
                                line_sum_q       <= line_total;
                                line_idx_q       <= line_cnt_q;
                                line_sum_valid_q <= 1'b1;
                                frame_acc_q      <= frame_total;
                                if (last_line) begin
                                    line_cnt_q    <= '0;
                                    frame_sum_q   <= frame_total;
                                    state_q       <= StOut;
                                    in_ready_q    <= 1'b0;
                                    frame_valid_q <= 1'b1;
                                end else begin
                                    line_cnt_q <= line_cnt_q + IW'(1);
                                end
                            end else begin
                                pix_cnt_q <= pix_cnt_q + CW'(1);
                            end
                        end
                    end
                    StOut: begin
                        if (bus_io.frame_ready) begin
                            state_q       <= StIdle;
                            frame_valid_q <= 1'b0;
                            busy_q        <= 1'b0;
                        end
                    end
                    default: begin
                        state_q       <= StIdle;
                        in_ready_q    <= 1'b0;
                        frame_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus_io.in_ready       = in_ready_q;
    assign bus_io.line_sum       = line_sum_q;
    assign bus_io.line_sum_valid = line_sum_valid_q;
    assign bus_io.line_idx       = line_idx_q;
    assign bus_io.frame_sum      = frame_sum_q;
    assign bus_io.frame_valid    = frame_valid_q;
    assign busy                  = busy_q;
endmodule

// File: tb/tb_frame_sum_sequencer.sv
// Directed bench for frame_sum_sequencer with LINE_SIZE=4, NUM_OF_LINES=2, PIXEL_SIZE=8.
module tb_frame_sum_sequencer;
    localparam int unsigned LS = 4;
    localparam int unsigned NL = 2;
    localparam int unsigned PS = 8;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic abort;
    logic busy;

    frame_sum_sequencer_if #(.LINE_SIZE(LS), .NUM_OF_LINES(NL), .PIXEL_SIZE(PS)) bus_if ();

    frame_sum_sequencer #(
        .LINE_SIZE    (LS),
        .NUM_OF_LINES (NL),
        .PIXEL_SIZE   (PS)
    ) u_dut (
        .CLK    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .busy   (busy),
        .bus_io (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ls_q[$];
    int li_q[$];
    int fv_cycles = 0;

    // Record every line strobe and every frame_valid cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_if.line_sum_valid === 1'b1) begin
            ls_q.push_back(int'(bus_if.line_sum));
            li_q.push_back(int'(bus_if.line_idx));
        end
        if (bus_if.frame_valid === 1'b1) fv_cycles++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_pair(input int a, input int b, input int gap);
        repeat (gap) tick();
        bus_if.pix_a    = 8'(a);
        bus_if.pix_b    = 8'(b);
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_line(input int a, input int b);
        for (int i = 0; i < int'(LS); i++) send_pair(a, b, 0);
    endtask

    task automatic check_line(input string tag, input int idx, input int exp_sum,
                              input int exp_idx);
        if (ls_q.size() > idx) begin
            check_eq(tag, ls_q[idx], exp_sum);
            check_eq({tag, "_idx"}, li_q[idx], exp_idx);
        end else begin
            check_eq({tag, "_present"}, ls_q.size(), idx + 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_in_ready"}, bus_if.in_ready, 0);
        check_eq({tag, "_lsv"}, bus_if.line_sum_valid, 0);
        check_eq({tag, "_fv"}, bus_if.frame_valid, 0);
        check_eq({tag, "_line_sum"}, bus_if.line_sum, 0);
        check_eq({tag, "_line_idx"}, bus_if.line_idx, 0);
        check_eq({tag, "_frame_sum"}, bus_if.frame_sum, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        int fv0;
        int gaps[8] = '{0, 2, 1, 3, 0, 1, 2, 0};

        reset              = 1'b0;
        start              = 1'b0;
        abort              = 1'b0;
        bus_if.in_valid    = 1'b0;
        bus_if.pix_a       = '0;
        bus_if.pix_b       = '0;
        bus_if.frame_ready = 1'b0;
        #1 reset = 1'b1;
        #2 check_all_zero("reset");
        #5 reset = 1'b0;
        tick();

        // Basic: ones, consumer always ready.
        bus_if.frame_ready = 1'b1;
        base = ls_q.size();
        fv0  = fv_cycles;
        start_frame();
        check_eq("basic_in_ready", bus_if.in_ready, 1);
        check_eq("basic_busy", busy, 1);
        send_line(1, 1);
        check_eq("basic_lsv0", bus_if.line_sum_valid, 1);
        check_eq("basic_line0", bus_if.line_sum, 4);
        check_eq("basic_fv_mid", bus_if.frame_valid, 0);
        send_line(1, 1);
        check_eq("basic_fv", bus_if.frame_valid, 1);
        check_eq("basic_in_ready_out", bus_if.in_ready, 0);
        check_eq("basic_lsv1", bus_if.line_sum_valid, 1);
        check_eq("basic_line1_idx", bus_if.line_idx, 1);
        check_eq("basic_frame", bus_if.frame_sum, 8);
        tick();
        check_eq("basic_fv_drop", bus_if.frame_valid, 0);
        check_eq("basic_idle", busy, 0);
        check_eq("basic_lsv_drop", bus_if.line_sum_valid, 0);
        tick();
        check_eq("basic_fv_cycles", fv_cycles - fv0, 1);
        check_eq("basic_nlines", ls_q.size() - base, 2);
        check_line("basic_l0", base, 4, 0);
        check_line("basic_l1", base + 1, 4, 1);

        // Max operands: no wrap.
        base = ls_q.size();
        start_frame();
        send_line(255, 255);
        check_eq("max_line0", bus_if.line_sum, 260100);
        send_line(255, 255);
        check_eq("max_line1", bus_if.line_sum, 260100);
        check_eq("max_frame", bus_if.frame_sum, 520200);
        tick();
        tick();
        check_eq("max_nlines", ls_q.size() - base, 2);

        // Input gaps and output backpressure; stray in_valid while not ready.
        bus_if.frame_ready = 1'b0;
        base = ls_q.size();
        fv0  = fv_cycles;
        start_frame();
        for (int i = 0; i < 8; i++) send_pair(i + 1, 2, gaps[i]);
        check_eq("bp_fv", bus_if.frame_valid, 1);
        check_eq("bp_frame", bus_if.frame_sum, 72);
        check_eq("bp_line1", bus_if.line_sum, 52);
        for (int i = 0; i < 5; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.pix_a    = 8'd99;
            bus_if.pix_b    = 8'd99;
            tick();
            check_eq("bp_hold_fv", bus_if.frame_valid, 1);
            check_eq("bp_hold_frame", bus_if.frame_sum, 72);
            check_eq("bp_hold_in_ready", bus_if.in_ready, 0);
        end
        bus_if.in_valid    = 1'b0;
        bus_if.frame_ready = 1'b1;
        tick();
        check_eq("bp_fv_drop", bus_if.frame_valid, 0);
        check_eq("bp_idle", busy, 0);
        check_eq("bp_frame_held", bus_if.frame_sum, 72);
        bus_if.in_valid = 1'b1;
        repeat (3) tick();
        bus_if.in_valid = 1'b0;
        tick();
        check_eq("bp_idle_stray", busy, 0);
        check_eq("bp_line_held", bus_if.line_sum, 52);
        check_eq("bp_fv_cycles", fv_cycles - fv0, 6);
        check_eq("bp_nlines", ls_q.size() - base, 2);
        check_line("bp_l0", base, 20, 0);
        check_line("bp_l1", base + 1, 52, 1);

        // Abort mid-line, then a clean frame of ones.
        base = ls_q.size();
        start_frame();
        for (int i = 0; i < 3; i++) send_pair(7, 7, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_in_ready", bus_if.in_ready, 0);
        check_eq("abort_line_held", bus_if.line_sum, 52);
        check_eq("abort_frame_held", bus_if.frame_sum, 72);
        tick();
        check_eq("abort_no_strobe", ls_q.size() - base, 0);
        start_frame();
        send_line(1, 1);
        check_eq("abort_new_line0", bus_if.line_sum, 4);
        check_eq("abort_frame_mid", bus_if.frame_sum, 72);
        send_line(1, 1);
        check_eq("abort_new_frame", bus_if.frame_sum, 8);
        tick();
        tick();
        check_eq("abort_nlines", ls_q.size() - base, 2);
        check_line("abort_l0", base, 4, 0);

        // Asynchronous reset during line 1, then a 2x3 frame.
        start_frame();
        send_line(1, 1);
        send_pair(1, 1, 0);
        send_pair(1, 1, 0);
        #1 reset = 1'b1;
        #1 check_all_zero("midreset");
        tick();
        reset = 1'b0;
        tick();
        check_all_zero("postreset");
        base = ls_q.size();
        start_frame();
        send_line(2, 3);
        check_eq("rst_line0", bus_if.line_sum, 24);
        send_line(2, 3);
        check_eq("rst_line1", bus_if.line_sum, 24);
        check_eq("rst_frame", bus_if.frame_sum, 48);
        tick();
        tick();
        check_line("rst_l0", base, 24, 0);
        check_line("rst_l1", base + 1, 24, 1);

        // start pulsed in RUN and in OUT must not restart anything.
        bus_if.frame_ready = 1'b0;
        base = ls_q.size();
        start_frame();
        send_pair(3, 1, 0);
        start = 1'b1;
        send_pair(3, 1, 0);
        start = 1'b0;
        for (int i = 0; i < 6; i++) send_pair(3, 1, 0);
        check_eq("sb_fv", bus_if.frame_valid, 1);
        check_eq("sb_frame", bus_if.frame_sum, 24);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("sb_out_fv", bus_if.frame_valid, 1);
        check_eq("sb_out_busy", busy, 1);
        check_eq("sb_out_in_ready", bus_if.in_ready, 0);
        bus_if.frame_ready = 1'b1;
        tick();
        check_eq("sb_fv_drop", bus_if.frame_valid, 0);
        check_eq("sb_idle", busy, 0);
        tick();
        check_eq("sb_nlines", ls_q.size() - base, 2);
        check_line("sb_l0", base, 12, 0);
        check_line("sb_l1", base + 1, 12, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
